// File: rtl/restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Define DIVIDER_SIGNED_EN for two's-complement operands (truncating toward zero).
module restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic             dz;

  logic [WIDTH+1:0] ext;
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;
  logic [WIDTH-1:0] dvd_orig;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;

`ifdef DIVIDER_SIGNED_EN
  logic dvd_neg;
  logic dsr_neg;

  assign dvd_mag  = dividend[WIDTH-1] ? -dividend : dividend;
  assign dsr_mag  = divisor[WIDTH-1] ? -divisor : divisor;
  assign dvd_orig = dvd_neg ? -q : q;
  assign q_final  = (dvd_neg ^ dsr_neg) ? -q_next : q_next;
  assign r_final  = dvd_neg ? -a_next[WIDTH-1:0] : a_next[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_neg <= 1'b0;
      dsr_neg <= 1'b0;
    end else if (state == IDLE && start) begin
      dvd_neg <= dividend[WIDTH-1];
      dsr_neg <= divisor[WIDTH-1];
    end
  end
`else
  assign dvd_mag  = dividend;
  assign dsr_mag  = divisor;
  assign dvd_orig = q;
  assign q_final  = q_next;
  assign r_final  = a_next[WIDTH-1:0];
`endif

  // Trial subtraction A - {0,D} as A + ~{0,D} + 1; one guard bit keeps the borrow visible.
  always_comb begin
    ext   = {a, q[WIDTH-1]};
    trial = ext + ~{2'b00, d} + {{(WIDTH+1){1'b0}}, 1'b1};
    if (!trial[WIDTH+1]) begin
      a_next = trial[WIDTH:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end else begin
      a_next = ext[WIDTH:0];
      q_next = {q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (count == CW'(1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == RUN);
    done        = (state == DONE);
    div_by_zero = (state == DONE) && dz;
  end

  // A zero divisor spends a single RUN cycle without iterating so its timing matches done at k+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      a         <= '0;
      q         <= '0;
      d         <= '0;
      dz        <= 1'b0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a     <= '0;
            q     <= dvd_mag;
            d     <= dsr_mag;
            dz    <= (divisor == '0);
            count <= (divisor == '0) ? CW'(1) : CW'(WIDTH);
          end
        end
        RUN: begin
          count <= count - CW'(1);
          if (!dz) begin
            a <= a_next;
            q <= q_next;
          end
          if (count == CW'(1)) begin
            quotient  <= dz ? '1 : q_final;
            remainder <= dz ? dvd_orig : r_final;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
